// File: rtl/axil_timer.sv
// axil_timer: AXI4-lite down-counter timer with auto-reload and level irq.
// Define AXIL_TIMER_PRESCALER_EN to add the PRESCALE register at 0x10.
module axil_timer #(
  parameter int AW = 32
) (
  input  logic          ACLK,
  input  logic          ARESETn,
  input  logic [AW-1:0] AWADDR,
  input  logic          AWVALID,
  output logic          AWREADY,
  input  logic [31:0]   WDATA,
  input  logic [3:0]    WSTRB,
  input  logic          WVALID,
  output logic          WREADY,
  output logic [1:0]    BRESP,
  output logic          BVALID,
  input  logic          BREADY,
  input  logic [AW-1:0] ARADDR,
  input  logic          ARVALID,
  output logic          ARREADY,
  output logic [31:0]   RDATA,
  output logic [1:0]    RRESP,
  output logic          RVALID,
  input  logic          RREADY,
  output logic          irq
);
  localparam int IW = AW - 2;

  logic          aw_held, w_held;
  logic [IW-1:0] aw_idx;
  logic [31:0]   w_data;
  logic [3:0]    w_strb;
  logic          aw_hs, w_hs, ar_hs, commit;
  logic [IW-1:0] widx, ridx;
  logic [31:0]   c_data;
  logic [3:0]    c_strb;
  logic          sel_ctrl, sel_load, sel_stat, sel_pre;
  logic          wr_ok, ctrl_wr, load_wr, stat_wr;
  logic [2:0]    ctrl_new;
  logic [31:0]   load_new;
  logic          en, auto_rl, irq_en, expired;
  logic [31:0]   load, count;
  logic          tick, stop, run, zero, hw_exp, w1c;
  logic          exp_nxt, ien_nxt;
  logic [31:0]   rd_val;
  logic          rd_ok;
  logic          unused_ok;

  assign unused_ok = ^{AWADDR[1:0], ARADDR[1:0]};

  assign AWREADY = !aw_held && !BVALID;
  assign WREADY  = !w_held && !BVALID;
  assign ARREADY = !RVALID;

  assign aw_hs  = AWVALID && AWREADY;
  assign w_hs   = WVALID && WREADY;
  assign ar_hs  = ARVALID && ARREADY;
  assign commit = (aw_held || aw_hs) && (w_held || w_hs) && !BVALID;

  assign widx   = aw_held ? aw_idx : AWADDR[AW-1:2];
  assign c_data = w_held ? w_data : WDATA;
  assign c_strb = w_held ? w_strb : WSTRB;
  assign ridx   = ARADDR[AW-1:2];

  // write address decode
  always_comb begin
    sel_ctrl = 1'b0;
    sel_load = 1'b0;
    sel_stat = 1'b0;
    sel_pre  = 1'b0;
    unique case (1'b1)
      widx == IW'(0): sel_ctrl = 1'b1;
      widx == IW'(1): sel_load = 1'b1;
      widx == IW'(3): sel_stat = 1'b1;
`ifdef AXIL_TIMER_PRESCALER_EN
      widx == IW'(4): sel_pre = 1'b1;
`endif
      default: ;
    endcase
  end

  assign wr_ok   = sel_ctrl || sel_load || sel_stat || sel_pre;
  assign ctrl_wr = commit && sel_ctrl;
  assign load_wr = commit && sel_load;
  assign stat_wr = commit && sel_stat;

  assign ctrl_new = c_strb[0] ? c_data[2:0]
                              : {irq_en, auto_rl, en};

  // per-lane merge of the new LOAD value
  always_comb begin
    load_new = load;
    for (int i = 0; i < 4; i++)
      if (c_strb[i]) load_new[8*i +: 8] = c_data[8*i +: 8];
  end

`ifdef AXIL_TIMER_PRESCALER_EN
  logic       pre_wr;
  logic [7:0] prescale, pcnt;

  assign pre_wr = commit && sel_pre;
  assign tick   = (pcnt == prescale);

  // prescale register and tick divider
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      prescale <= '0;
      pcnt     <= '0;
    end else begin
      if (pre_wr && c_strb[0]) prescale <= c_data[7:0];
      if (pre_wr || ctrl_wr || tick) pcnt <= '0;
      else pcnt <= pcnt + 8'd1;
    end
  end
`else
  assign tick = 1'b1;
`endif

  assign stop    = ctrl_wr && !ctrl_new[0];
  assign run     = en && tick && !stop;
  assign zero    = (count == '0);
  assign hw_exp  = run && zero;
  assign w1c     = stat_wr && c_strb[0] && c_data[0];
  assign exp_nxt = hw_exp || (expired && !w1c);
  assign ien_nxt = ctrl_wr ? ctrl_new[2] : irq_en;

  // timer registers, counter and interrupt
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      en      <= 1'b0;
      auto_rl <= 1'b0;
      irq_en  <= 1'b0;
      load    <= '0;
      count   <= '0;
      expired <= 1'b0;
      irq     <= 1'b0;
    end else begin
      if (ctrl_wr) {irq_en, auto_rl, en} <= ctrl_new;
      else if (hw_exp && !auto_rl) en <= 1'b0;
      if (load_wr) load <= load_new;
      if (load_wr) count <= load_new;
      else if (run) count <= zero ? (auto_rl ? load : '0)
                                  : count - 32'd1;
      expired <= exp_nxt;
      irq     <= exp_nxt && ien_nxt;
    end
  end

  // write channel buffers and response
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      aw_held <= 1'b0;
      aw_idx  <= '0;
      w_held  <= 1'b0;
      w_data  <= '0;
      w_strb  <= '0;
      BVALID  <= 1'b0;
      BRESP   <= 2'b00;
    end else begin
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        BVALID  <= 1'b1;
        BRESP   <= wr_ok ? 2'b00 : 2'b10;
      end else begin
        if (aw_hs) begin
          aw_held <= 1'b1;
          aw_idx  <= AWADDR[AW-1:2];
        end
        if (w_hs) begin
          w_held <= 1'b1;
          w_data <= WDATA;
          w_strb <= WSTRB;
        end
        if (BVALID && BREADY) BVALID <= 1'b0;
      end
    end
  end

  // read data mux
  always_comb begin
    rd_val = '0;
    rd_ok  = 1'b1;
    unique case (1'b1)
      ridx == IW'(0): rd_val = {29'b0, irq_en, auto_rl, en};
      ridx == IW'(1): rd_val = load;
      ridx == IW'(2): rd_val = count;
      ridx == IW'(3): rd_val = {31'b0, expired};
`ifdef AXIL_TIMER_PRESCALER_EN
      ridx == IW'(4): rd_val = {24'b0, prescale};
`endif
      default: rd_ok = 1'b0;
    endcase
  end

  // read response register
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      RVALID <= 1'b0;
      RDATA  <= '0;
      RRESP  <= 2'b00;
    end else if (ar_hs) begin
      RVALID <= 1'b1;
      RDATA  <= rd_ok ? rd_val : '0;
      RRESP  <= rd_ok ? 2'b00 : 2'b10;
    end else if (RVALID && RREADY) begin
      RVALID <= 1'b0;
    end
  end
endmodule

// File: tb/tb_axil_timer.sv
// tb_axil_timer: randomized AXI-lite traffic against a register-level model.
// Directed sequences cover handshakes, expiry, SLVERR and reset abort.
module tb_axil_timer;
  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic        AWVALID, AWREADY, WVALID, WREADY;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP, RRESP;
  logic        BVALID, BREADY, ARVALID, ARREADY;
  logic        RVALID, RREADY, irq;

  int n_vec = 0;
  int n_err = 0;

  axil_timer #(.AW(32)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID),
    .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID),
    .RREADY(RREADY), .irq(irq)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // reference model state
  logic        m_en, m_auto, m_ien, m_exp, m_irq;
  logic [31:0] m_load, m_count;
  logic [7:0]  m_pre;
  int          m_phase;
  logic        m_wr_valid = 1'b0, m_rd_valid = 1'b0;
  logic [31:0] m_wr_addr, m_wr_data, m_rd_addr, m_rd_data;
  logic [3:0]  m_wr_strb;
  logic [1:0]  m_rd_resp;

  assign m_irq = m_exp & m_ien;

  function automatic bit mapped(input logic [31:0] a);
    logic [29:0] i = a[31:2];
`ifdef AXIL_TIMER_PRESCALER_EN
    if (i == 4) return 1'b1;
`endif
    return (i == 0) || (i == 1) || (i == 3);
  endfunction

  function automatic logic [33:0] m_read(input logic [31:0] a);
    logic [29:0] i = a[31:2];
    if (i == 0) return {2'b00, 29'b0, m_ien, m_auto, m_en};
    if (i == 1) return {2'b00, m_load};
    if (i == 2) return {2'b00, m_count};
    if (i == 3) return {2'b00, 31'b0, m_exp};
`ifdef AXIL_TIMER_PRESCALER_EN
    if (i == 4) return {2'b00, 24'b0, m_pre};
`endif
    return {2'b10, 32'b0};
  endfunction

  always @(posedge ACLK or negedge ARESETn) begin : model
    logic [29:0] wi;
    logic        tk, wc, wl, ws, wp, fire;
    logic [2:0]  nctl;
    logic [31:0] nld, ncnt;
    logic        nen, nexp;
    if (!ARESETn) begin
      m_en <= 0; m_auto <= 0; m_ien <= 0; m_exp <= 0;
      m_load <= 0; m_count <= 0; m_pre <= 0; m_phase <= 0;
    end else begin
      if (m_rd_valid) {m_rd_resp, m_rd_data} <= m_read(m_rd_addr);
      tk = 1'b1;
      wp = 1'b0;
      wi = m_wr_addr[31:2];
`ifdef AXIL_TIMER_PRESCALER_EN
      tk = (m_phase == int'(m_pre));
      wp = m_wr_valid && wi == 4;
`endif
      wc = m_wr_valid && wi == 0;
      wl = m_wr_valid && wi == 1;
      ws = m_wr_valid && wi == 3;
      nctl = m_wr_strb[0] ? m_wr_data[2:0] : {m_ien, m_auto, m_en};
      nld = m_load;
      for (int i = 0; i < 4; i++)
        if (m_wr_strb[i]) nld[8*i +: 8] = m_wr_data[8*i +: 8];
      fire = m_en && tk && !(wc && !nctl[0]);
      ncnt = m_count; nen = m_en; nexp = m_exp;
      if (ws && m_wr_strb[0] && m_wr_data[0]) nexp = 1'b0;
      if (fire) begin
        if (m_count != 0) ncnt = m_count - 1;
        else begin
          nexp = 1'b1;
          if (m_auto) ncnt = m_load;
          else nen = 1'b0;
        end
      end
      if (wc) begin
        nen = nctl[0];
        m_auto <= nctl[1];
        m_ien <= nctl[2];
      end
      if (wl) begin
        m_load <= nld;
        ncnt = nld;
      end
      m_count <= ncnt;
      m_en <= nen;
      m_exp <= nexp;
      if (wp && m_wr_strb[0]) m_pre <= m_wr_data[7:0];
      m_phase <= (wp || wc || tk) ? 0 : m_phase + 1;
    end
  end

  // irq is compared against the model every cycle
  always @(posedge ACLK) begin
    #3;
    check("irq", {31'b0, irq}, {31'b0, m_irq});
  end

  task automatic axil_wr(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int lead,
                         input int hold, input bit rst_mid);
    logic [1:0] er = mapped(a) ? 2'b00 : 2'b10;
    if (lead > 0) begin
      @(negedge ACLK);
      WDATA = d; WSTRB = s; WVALID = 1'b1;
      repeat (lead) begin
        @(negedge ACLK);
        WVALID = 1'b0;
        check("wready_held", {31'b0, WREADY}, 0);
      end
    end else begin
      @(negedge ACLK);
      WDATA = d; WSTRB = s; WVALID = 1'b1;
    end
    AWADDR = a; AWVALID = 1'b1;
    m_wr_addr = a; m_wr_data = d; m_wr_strb = s; m_wr_valid = 1'b1;
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0; m_wr_valid = 1'b0;
    check("bvalid", {31'b0, BVALID}, 1);
    check("bresp", {30'b0, BRESP}, {30'b0, er});
    repeat (hold) begin
      @(negedge ACLK);
      check("bvalid_hold", {31'b0, BVALID}, 1);
      check("bresp_hold", {30'b0, BRESP}, {30'b0, er});
      check("awready_hold", {31'b0, AWREADY}, 0);
      check("wready_hold", {31'b0, WREADY}, 0);
    end
    if (rst_mid) begin
      ARESETn = 1'b0;
      #1;
      check("bvalid_rst", {31'b0, BVALID}, 0);
      @(negedge ACLK);
      ARESETn = 1'b1;
      return;
    end
    BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;
    check("bvalid_clr", {31'b0, BVALID}, 0);
  endtask

  task automatic axil_rd(input logic [31:0] a, input int hold,
                         output logic [31:0] d,
                         output logic [1:0] r);
    @(negedge ACLK);
    ARADDR = a; ARVALID = 1'b1;
    m_rd_addr = a; m_rd_valid = 1'b1;
    @(negedge ACLK);
    ARVALID = 1'b0; m_rd_valid = 1'b0;
    check("rvalid", {31'b0, RVALID}, 1);
    check("rdata", RDATA, m_rd_data);
    check("rresp", {30'b0, RRESP}, {30'b0, m_rd_resp});
    d = RDATA;
    r = RRESP;
    repeat (hold) begin
      @(negedge ACLK);
      check("rvalid_hold", {31'b0, RVALID}, 1);
      check("rdata_hold", RDATA, m_rd_data);
      check("arready_hold", {31'b0, ARREADY}, 0);
    end
    RREADY = 1'b1;
    @(negedge ACLK);
    RREADY = 1'b0;
    check("rvalid_clr", {31'b0, RVALID}, 0);
  endtask

  logic [31:0] offs [7] = '{32'h0, 32'h4, 32'h8, 32'hC,
                            32'h10, 32'h14, 32'h100};

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int          k;
    ARESETn = 1'b0;
    AWADDR = 0; AWVALID = 0; WDATA = 0; WSTRB = 0; WVALID = 0;
    BREADY = 0; ARADDR = 0; ARVALID = 0; RREADY = 0;
    repeat (3) @(negedge ACLK);
    check("rst_bvalid", {31'b0, BVALID}, 0);
    check("rst_rvalid", {31'b0, RVALID}, 0);
    check("rst_rdata", RDATA, 0);
    check("rst_bresp", {30'b0, BRESP}, 0);
    check("rst_rresp", {30'b0, RRESP}, 0);
    ARESETn = 1'b1;
    @(negedge ACLK);
    check("rst_awready", {31'b0, AWREADY}, 1);
    check("rst_wready", {31'b0, WREADY}, 1);
    check("rst_arready", {31'b0, ARREADY}, 1);

    axil_wr(32'h4, 32'h5, 4'hF, 0, 0, 0);
    axil_rd(32'h8, 0, d, r);
    check("count_eq_load", d, 32'd5);

    axil_wr(32'h0, 32'h3, 4'hF, 2, 0, 0);
    axil_rd(32'h0, 1, d, r);
    check("ctrl_rd", d, 32'h3);

    axil_wr(32'h0, 32'h0, 4'hF, 0, 0, 0);
    axil_wr(32'h4, 32'h3, 4'hF, 0, 0, 0);
    axil_wr(32'h0, 32'h7, 4'hF, 0, 0, 0);
    k = 0;
    while (irq !== 1'b1 && k < 20) begin
      @(negedge ACLK);
      k++;
    end
    check("irq_rise", {31'b0, irq}, 1);
    axil_wr(32'hC, 32'h1, 4'hF, 0, 0, 0);
    axil_wr(32'h0, 32'h0, 4'hF, 0, 0, 0);
    axil_wr(32'hC, 32'h1, 4'hF, 0, 0, 0);
    axil_rd(32'hC, 0, d, r);
    check("status_clr", d, 32'h0);

    axil_wr(32'h4, 32'h2, 4'hF, 0, 0, 0);
    axil_wr(32'h0, 32'h1, 4'hF, 0, 0, 0);
    repeat (8) @(negedge ACLK);
    axil_rd(32'h0, 0, d, r);
    check("ctrl_en_off", d, 32'h0);
    axil_rd(32'hC, 0, d, r);
    check("status_exp", d, 32'h1);
    axil_rd(32'h8, 0, d, r);
    check("count_zero", d, 32'h0);
    axil_rd(32'h14, 0, d, r);
    check("unmapped_rresp", {30'b0, r}, 32'h2);
    check("unmapped_rdata", d, 32'h0);
    axil_wr(32'h8, 32'h9, 4'hF, 0, 0, 0);
    axil_rd(32'h10, 0, d, r);

    axil_wr(32'h4, 32'h9, 4'hF, 0, 5, 0);
    axil_wr(32'h4, 32'h7, 4'h1, 0, 2, 1);
    @(negedge ACLK);
    check("post_rst_awready", {31'b0, AWREADY}, 1);
    check("post_rst_wready", {31'b0, WREADY}, 1);
    axil_rd(32'h4, 0, d, r);
    check("post_rst_load", d, 32'h0);

`ifdef AXIL_TIMER_PRESCALER_EN
    axil_wr(32'h10, 32'h3, 4'hF, 0, 0, 0);
    axil_wr(32'h4, 32'h2, 4'hF, 0, 0, 0);
    axil_wr(32'h0, 32'h1, 4'hF, 0, 0, 0);
    repeat (4) axil_rd(32'h8, 0, d, r);
    axil_wr(32'h10, 32'h0, 4'hF, 0, 0, 0);
`endif

    repeat (300) begin
      int          op;
      logic [31:0] a, wd, base;
      logic [3:0]  s;
      op = $urandom_range(0, 2);
      a = offs[$urandom_range(0, 6)] | 32'($urandom_range(0, 3));
      base = a & ~32'h3;
      if (base == 32'h4) wd = $urandom_range(0, 12);
      else if (base == 32'h10) wd = $urandom_range(0, 3);
      else wd = $urandom;
      s = ($urandom_range(0, 1) == 1) ? 4'hF
                                      : 4'($urandom_range(0, 15));
      if (op == 0)
        axil_wr(a, wd, s, $urandom_range(0, 2),
                $urandom_range(0, 2), 0);
      else if (op == 1)
        axil_rd(a, $urandom_range(0, 2), d, r);
      else
        repeat ($urandom_range(1, 4)) @(negedge ACLK);
    end

    @(negedge ACLK);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/axil_timer.md
AXIL_TIMER -- requirements
Module: axil_timer

Interface
REQ-001 SHALL have parameter AW, default 32, AXI-lite address width; data width is fixed at 32.
REQ-002 SHALL have one clock and an asynchronous active-low reset: ACLK input 1 clock (all logic on rising edge); ARESETn input 1 async active-low reset.
REQ-003 SHALL have write address ports: AWADDR input AW; AWVALID input 1; AWREADY output 1.
REQ-004 SHALL have write data ports: WDATA input 32; WSTRB input 4; WVALID input 1; WREADY output 1.
REQ-005 SHALL have write response ports: BRESP output 2; BVALID output 1; BREADY input 1.
REQ-006 SHALL have read address ports: ARADDR input AW; ARVALID input 1; ARREADY output 1.
REQ-007 SHALL have read data ports: RDATA output 32; RRESP output 2; RVALID output 1; RREADY input 1.
REQ-008 SHALL have irq output 1, level interrupt equal to STATUS.EXPIRED & CTRL.IRQ_EN, driven from flops.

Function
REQ-009 SHALL decode ADDR[AW-1:2] and ignore ADDR[1:0].
REQ-010 SHALL implement the register map: 0x0 CTRL RW (bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN, others read 0); 0x4 LOAD RW 32b; 0x8 COUNT RO; 0xC STATUS (bit0 EXPIRED, write-1-to-clear).
REQ-011 SHALL respond SLVERR (2'b10) with RDATA=0 and no state change for unmapped offsets and for writes to COUNT; it SHALL respond OKAY (2'b00) otherwise.
REQ-012 SHALL accept AW and W independently: AWREADY = !aw_held & !BVALID and WREADY = !w_held & !BVALID, each channel held in its own buffer after handshake.
REQ-013 SHALL commit a write on the edge where address and data are both available (held, or handshaking that cycle) and BVALID=0; BVALID SHALL rise on that same edge, so simultaneous AW+W gives BVALID the next cycle.
REQ-014 SHALL hold BVALID/BRESP stable until BREADY=1; both buffers SHALL clear at commit; no second write response outstanding.
REQ-015 SHALL apply WSTRB per byte lane to CTRL and LOAD; STATUS W1C SHALL use WDATA[0] only when WSTRB[0]=1.
REQ-016 SHALL set ARREADY = !RVALID; on AR handshake it SHALL register RDATA/RRESP and assert RVALID next cycle, holding both stable until RREADY=1; COUNT is sampled at the AR handshake edge.
REQ-017 SHALL, while EN=1 and COUNT!=0, decrement COUNT by 1 per tick (tick = every cycle unless REQ-024 applies).
REQ-018 SHALL, on a tick with EN=1 and COUNT==0, set EXPIRED; then COUNT<=LOAD if AUTO_RELOAD=1, else EN<=0 and COUNT stays 0.
REQ-019 SHALL load COUNT with the strobe-merged new LOAD value on a LOAD write; this SHALL take priority over decrement/reload in that cycle.
REQ-020 SHALL let a hardware EXPIRED set win over a simultaneous W1C.
REQ-021 SHALL let a CTRL write clearing EN freeze COUNT at the value it held before that edge.

Reset
REQ-022 SHALL, on ARESETn=0, asynchronously clear all registers, COUNT, buffers, BVALID, RVALID, BRESP, RRESP, RDATA and irq to 0, making AWREADY/WREADY/ARREADY 1 after deassertion.
REQ-023 SHALL, on reset mid-transaction, drop outstanding transactions without issuing a response.

Configuration
REQ-024 SHALL, with AXIL_TIMER_PRESCALER_EN defined, add PRESCALE RW (bits 7:0, reset 0) at 0x10 and generate a tick once every PRESCALE+1 cycles via an 8-bit prescale counter cleared on any PRESCALE or CTRL write.
REQ-025 SHALL, without AXIL_TIMER_PRESCALER_EN, tick every cycle and decode 0x10 as unmapped (SLVERR).

Verification
REQ-026 SHALL verify: AW+W same cycle to 0x4 with WDATA=0x0000_0005, WSTRB=0xF -> BVALID next cycle, BRESP=00; read 0x8 -> RDATA=5.
REQ-027 SHALL verify: W two cycles before AW to 0x0 with WDATA=0x3 -> WREADY low until commit, single OKAY response; read 0x0 -> 0x3.
REQ-028 SHALL verify: LOAD=3, CTRL=0x7 (auto-reload, irq) -> COUNT 3,2,1,0,3 over successive cycles; EXPIRED and irq = 1 after reaching 0; write 0xC WDATA=1 -> irq=0.
REQ-029 SHALL verify: LOAD=2, CTRL=0x1 -> COUNT reaches 0 and EN reads 0 with EXPIRED=1; read 0x14 -> RRESP=10, RDATA=0.
REQ-030 SHALL verify: BREADY=0 for 5 cycles -> BVALID/BRESP stable and AWREADY=WREADY=0; ARESETn pulsed low during a held response -> BVALID=0 immediately.
REQ-031 SHALL verify, with AXIL_TIMER_PRESCALER_EN: PRESCALE=3, LOAD=2, CTRL=0x1 -> COUNT decrements every 4 cycles.
